frac_reduce_ctrl: RTL and testbench

FRAC_REDUCE_CTRL -- requirements
Module: frac_reduce_ctrl

---
 rtl/frac_reduce_pkg.sv | 22 ++
 rtl/frac_reduce_pulse_rise.sv | 23 ++
 rtl/frac_reduce_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_frac_reduce_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/frac_reduce_pkg.sv
// Shared types and constants for the fraction-reduction controller.
package frac_reduce_pkg;

  localparam int W_DEFAULT = 4;
  localparam int CYC_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GCD  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [CYC_W-1:0] sat_inc8(input logic [CYC_W-1:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/frac_reduce_pulse_rise.sv
// Rising-edge detector; a level held high through reset must fall before it can fire.
module pulse_rise (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic pulse_out
);

  // low_q means "previous sample was low"; cleared by reset so a held level is not an edge
  logic low_q;

  // History register
  always_ff @(posedge clk) begin
    if (rst) begin
      low_q <= 1'b0;
    end else begin
      low_q <= ~level_in;
    end
  end

  assign pulse_out = level_in & low_q;

endmodule

// File: rtl/frac_reduce_ctrl.sv
// Reduces a/b to lowest terms via subtractive GCD then repeated-subtraction division.
// Optional macro FRAC_REDUCE_CYCLE_CNT_EN adds cyc_out, the busy-cycle count of the last operation.
module frac_reduce_ctrl
  import frac_reduce_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_in,
  input  logic         abort_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] gcd_out,
  output logic [W-1:0] num_out,
  output logic [W-1:0] den_out
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
  ,
  output logic [7:0]   cyc_out
`endif
);

  localparam logic [W-1:0] ZERO_W = {W{1'b0}};
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic [W-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [W-1:0] g_q, g_d, qa_q, qa_d, qb_q, qb_d;
  logic [W-1:0] gcd_q, gcd_d, num_q, num_d, den_q, den_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic         start_pulse_s;

  pulse_rise u_start_edge (
    .clk       (clk),
    .rst       (rst),
    .level_in  (start_in),
    .pulse_out (start_pulse_s)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    g_d     = g_q;
    qa_d    = qa_q;
    qb_d    = qb_q;
    gcd_d   = gcd_q;
    num_d   = num_q;
    den_d   = den_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // abort in the same cycle as the edge swallows the start
        if (start_pulse_s && !abort_in) begin
          x_d     = a_in;
          y_d     = b_in;
          ra_d    = a_in;
          rb_d    = b_in;
          g_d     = ZERO_W;
          qa_d    = ZERO_W;
          qb_d    = ZERO_W;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_GCD;
        end else begin
          busy_d  = 1'b0;
        end
      end
      ST_GCD: begin
        if (abort_in) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if ((x_q == ZERO_W) || (y_q == ZERO_W)) begin
          err_d   = 1'b1;
          gcd_d   = ZERO_W;
          num_d   = ZERO_W;
          den_d   = ZERO_W;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else if (y_q > x_q) begin
          y_d = y_q - x_q;
        end else begin
          g_d     = x_q;
          state_d = ST_DIV;
        end
      end
      ST_DIV: begin
        if (abort_in) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if ((ra_q == ZERO_W) && (rb_q == ZERO_W)) begin
          gcd_d   = g_q;
          num_d   = qa_q;
          den_d   = qb_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          if ((ra_q != ZERO_W) && (ra_q >= g_q)) begin
            ra_d = ra_q - g_q;
            qa_d = qa_q + ONE_W;
          end else begin
            ra_d = ra_q;
          end
          if ((rb_q != ZERO_W) && (rb_q >= g_q)) begin
            rb_d = rb_q - g_q;
            qb_d = qb_q + ONE_W;
          end else begin
            rb_d = rb_q;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= ZERO_W;
      y_q     <= ZERO_W;
      ra_q    <= ZERO_W;
      rb_q    <= ZERO_W;
      g_q     <= ZERO_W;
      qa_q    <= ZERO_W;
      qb_q    <= ZERO_W;
      gcd_q   <= ZERO_W;
      num_q   <= ZERO_W;
      den_q   <= ZERO_W;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      g_q     <= g_d;
      qa_q    <= qa_d;
      qb_q    <= qb_d;
      gcd_q   <= gcd_d;
      num_q   <= num_d;
      den_q   <= den_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign gcd_out = gcd_q;
  assign num_out = num_q;
  assign den_out = den_q;

`ifdef FRAC_REDUCE_CYCLE_CNT_EN
  logic [7:0] cnt_q, cnt_d, cyc_q, cyc_d;
  logic       running_s, leaving_s;

  assign running_s = (state_q == ST_GCD) || (state_q == ST_DIV);
  assign leaving_s = running_s && ((state_d == ST_DONE) || (state_d == ST_IDLE));

  // Busy-cycle counter; snapshot taken as the operation completes or aborts
  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if ((state_q == ST_IDLE) && (state_d == ST_GCD)) begin
      cnt_d = 8'd0;
    end else if (running_s) begin
      cnt_d = sat_inc8(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
    if (leaving_s) begin
      cyc_d = sat_inc8(cnt_q);
    end else begin
      cyc_d = cyc_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      cyc_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cyc_out = cyc_q;
`endif

endmodule

// File: tb/tb_frac_reduce_ctrl.sv
// Directed self-checking bench for frac_reduce_ctrl (W=4).
module tb_frac_reduce_ctrl;

  logic       clk = 1'b0;
  logic       rst, start_in, abort_in;
  logic [3:0] a_in, b_in;
  logic       busy, done, err;
  logic [3:0] gcd_out, num_out, den_out;
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
  logic [7:0] cyc_out;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;

  frac_reduce_ctrl #(.W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_in (start_in),
    .abort_in (abort_in),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .gcd_out  (gcd_out),
    .num_out  (num_out),
    .den_out  (den_out)
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    ,
    .cyc_out  (cyc_out)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    a_in = a;
    b_in = b;
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset;
    int d0;
    rst = 1'b1; start_in = 1'b0; abort_in = 1'b0; a_in = 4'd0; b_in = 4'd0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== 12'h000) begin n_fail++; $display("FAIL reset_outs: got %0d/%0d/%0d want 0/0/0", gcd_out, num_out, den_out); end
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    n_cmp++; if (cyc_out !== 8'd0) begin n_fail++; $display("FAIL reset_cyc: got %0d want 0", cyc_out); end
`endif
    // start held high through reset release must not launch
    d0 = done_cnt;
    rst = 1'b1; start_in = 1'b1; a_in = 4'd5; b_in = 4'd10;
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_start_busy: got %0b want 0", busy); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL held_start_done: got %0d want 0", done_cnt - d0); end
    start_in = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    int lat, d0;
    d0 = done_cnt;
    launch(4'd6, 4'd4);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
    wait_done(lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    n_cmp++; if (gcd_out !== 4'd2) begin n_fail++; $display("FAIL basic_gcd: got %0d want 2", gcd_out); end
    n_cmp++; if (num_out !== 4'd3) begin n_fail++; $display("FAIL basic_num: got %0d want 3", num_out); end
    n_cmp++; if (den_out !== 4'd2) begin n_fail++; $display("FAIL basic_den: got %0d want 2", den_out); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %0b want 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b want 0", busy); end
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    n_cmp++; if (cyc_out !== 8'd7) begin n_fail++; $display("FAIL basic_cyc: got %0d want 7", cyc_out); end
`endif
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %0b want 0", done); end
    idle(3);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_worst_case;
    int lat;
    launch(4'd15, 4'd1);
    wait_done(lat);
    n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL worst_latency: got %0d want 32", lat); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd1, 4'd15, 4'd1}) begin n_fail++; $display("FAIL worst_result: got %0d/%0d/%0d want 1/15/1", gcd_out, num_out, den_out); end
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    n_cmp++; if (cyc_out !== 8'd31) begin n_fail++; $display("FAIL worst_cyc: got %0d want 31", cyc_out); end
`endif
    idle(2);
  endtask

  task automatic test_zero_operand;
    int lat;
    launch(4'd0, 4'd7);
    wait_done(lat);
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %0b want 1", err); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== 12'h000) begin n_fail++; $display("FAIL zero_outs: got %0d/%0d/%0d want 0/0/0", gcd_out, num_out, den_out); end
    idle(3);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL zero_err_held: got %0b want 1", err); end
    launch(4'd9, 4'd9);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL nine_err_cleared: got %0b want 0", err); end
    wait_done(lat);
    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL nine_latency: got %0d want 4", lat); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd9, 4'd1, 4'd1}) begin n_fail++; $display("FAIL nine_result: got %0d/%0d/%0d want 9/1/1", gcd_out, num_out, den_out); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL nine_err: got %0b want 0", err); end
    idle(2);
  endtask

  task automatic test_back_to_back;
    int lat, d0;
    d0 = done_cnt;
    launch(4'd8, 4'd12);
    idle(2);
    launch(4'd5, 4'd5);
    wait_done(lat);
    n_cmp++; if (lat < 0) begin n_fail++; $display("FAIL b2b_timeout: got %0d want done", lat); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd4, 4'd2, 4'd3}) begin n_fail++; $display("FAIL b2b_result: got %0d/%0d/%0d want 4/2/3", gcd_out, num_out, den_out); end
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    n_cmp++; if (cyc_out !== 8'd7) begin n_fail++; $display("FAIL b2b_cyc: got %0d want 7", cyc_out); end
`endif
    idle(20);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_cnt;
    launch(4'd15, 4'd1);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b want 0", busy); end
    idle(40);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd4, 4'd2, 4'd3}) begin n_fail++; $display("FAIL abort_held: got %0d/%0d/%0d want 4/2/3", gcd_out, num_out, den_out); end
`ifdef FRAC_REDUCE_CYCLE_CNT_EN
    n_cmp++; if (cyc_out !== 8'd1) begin n_fail++; $display("FAIL abort_cyc: got %0d want 1", cyc_out); end
`endif
    // reset during DIV
    d0 = done_cnt;
    launch(4'd6, 4'd4);
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_div_flags: got %03b want 000", {busy, done, err}); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== 12'h000) begin n_fail++; $display("FAIL rst_div_outs: got %0d/%0d/%0d want 0/0/0", gcd_out, num_out, den_out); end
    idle(20);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rst_div_no_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_start_held;
    int d0;
    d0 = done_cnt;
    a_in = 4'd3; b_in = 4'd6; start_in = 1'b1;
    idle(10);
    start_in = 1'b0;
    idle(5);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL held_ops: got %0d want 1", done_cnt - d0); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd3, 4'd1, 4'd2}) begin n_fail++; $display("FAIL held_result: got %0d/%0d/%0d want 3/1/2", gcd_out, num_out, den_out); end
    // start edge coinciding with abort is dropped
    d0 = done_cnt;
    a_in = 4'd10; b_in = 4'd4; start_in = 1'b1; abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_busy: got %0b want 0", busy); end
    idle(3);
    start_in = 1'b0;
    idle(30);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL start_abort_ops: got %0d want 0", done_cnt - d0); end
    n_cmp++; if ({gcd_out, num_out, den_out} !== {4'd3, 4'd1, 4'd2}) begin n_fail++; $display("FAIL start_abort_held: got %0d/%0d/%0d want 3/1/2", gcd_out, num_out, den_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_worst_case();
    test_zero_operand();
    test_back_to_back();
    test_abort();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
